// File: rtl/ps2_kbd_receiver_pkg.sv
// Shared constants, frame layout and parity helpers for the PS/2 keyboard receiver.
package ps2_kbd_receiver_pkg;

   localparam int unsigned PS2_FRAME_BITS = 11;
   localparam int unsigned PS2_CNT_W      = 4;
   localparam logic [7:0]  PS2_BREAK_CODE = 8'hF0;
   localparam logic [7:0]  PS2_EXT_CODE   = 8'hE0;

   // Bit 0 is the first bit on the wire.
   typedef struct packed {
      logic       stop;
      logic       parity;
      logic [7:0] data;
      logic       start;
   } ps2_frame_t;

   function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
      return ^{d, p};
   endfunction

   function automatic logic frame_ok(input ps2_frame_t f);
      return !f.start && f.stop && odd_parity_ok(f.data, f.parity);
   endfunction

endpackage

// File: rtl/ps2_kbd_receiver_if.sv
// Host-side byte interface: pop strobe from the consumer, head byte and status back.
interface ps2_kbd_receiver_if;
   logic       nextdata_n;
   logic [7:0] data;
   logic       ready;
   logic       overflow;

   modport master (output nextdata_n, input data, ready, overflow);
   modport slave  (input nextdata_n, output data, ready, overflow);
endinterface

// File: rtl/ps2_kbd_receiver_fifo.sv
// Byte FIFO with wrap-bit pointers, registered head/ready and a sticky overflow flag.
module ps2_rx_fifo #(
   parameter int unsigned DEPTH = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push,
   input  logic [7:0] wdata,
   input  logic       pop,
   output logic [7:0] rdata,
   output logic       ready,
   output logic       overflow
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned PW = AW + 1;

   logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [7:0]    mem_q [DEPTH];
   logic [7:0]    mem_d [DEPTH];
   logic [7:0]    rdata_q, rdata_d;
   logic          ready_q, ready_d;
   logic          overflow_q, overflow_d;
   logic          empty_c, full_c, pop_ok_c, push_ok_c;

   assign empty_c = (wr_q == rd_q);
   assign full_c  = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);

   // Pop is resolved first so a push into a full FIFO succeeds when a pop frees a slot.
   always_comb begin
      pop_ok_c   = pop && !empty_c;
      push_ok_c  = push && (!full_c || pop_ok_c);
      mem_d      = mem_q;
      wr_d       = wr_q;
      rd_d       = rd_q;
      overflow_d = overflow_q | (push && !push_ok_c);
      if (push_ok_c) begin
         mem_d[wr_q[AW-1:0]] = wdata;
         wr_d                = wr_q + PW'(1);
      end
      if (pop_ok_c) begin
         rd_d = rd_q + PW'(1);
      end
      ready_d = (wr_d != rd_d);
      rdata_d = mem_d[rd_d[AW-1:0]];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q       <= '0;
         rd_q       <= '0;
         rdata_q    <= '0;
         ready_q    <= 1'b0;
         overflow_q <= 1'b0;
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      end else begin
         wr_q       <= wr_d;
         rd_q       <= rd_d;
         rdata_q    <= rdata_d;
         ready_q    <= ready_d;
         overflow_q <= overflow_d;
         mem_q      <= mem_d;
      end
   end

   assign rdata    = rdata_q;
   assign ready    = ready_q;
   assign overflow = overflow_q;

endmodule

// File: rtl/ps2_kbd_receiver.sv
// PS/2 keyboard receive front end: line synchronisers, 11-bit frame deserialiser, byte FIFO.
module ps2_kbd_receiver
   import ps2_kbd_receiver_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH   = 8,
   parameter int unsigned SYNC_STAGES  = 3,
   parameter int unsigned IDLE_TIMEOUT = 50000
) (
   input  logic                 clk,
   input  logic                 clrn,
   input  logic                 ps2_clk,
   input  logic                 ps2_data,
   ps2_kbd_receiver_if.slave    host
);

   localparam int unsigned TW = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
   localparam int unsigned SW = PS2_FRAME_BITS - 1;

   logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
   logic [1:0]             data_sync_q, data_sync_d;
   logic [SW-1:0]          shift_q, shift_d;
   logic [PS2_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic [TW-1:0]          idle_q, idle_d;
   logic                   push_q, push_d;
   logic [7:0]             byte_q, byte_d;
   logic                   fall_c;
   logic                   bit_c;
   ps2_frame_t             frame_c;

   assign fall_c  = clk_sync_q[SYNC_STAGES-1] & ~clk_sync_q[SYNC_STAGES-2];
   assign bit_c   = data_sync_q[1];
   assign frame_c = ps2_frame_t'({bit_c, shift_q});

   // New bits enter at the top so the first (start) bit ends up at index 0.
   always_comb begin
      clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
      data_sync_d = {data_sync_q[0], ps2_data};
      shift_d     = shift_q;
      bit_cnt_d   = bit_cnt_q;
      idle_d      = '0;
      push_d      = 1'b0;
      byte_d      = byte_q;
      if (fall_c) begin
         shift_d = {bit_c, shift_q[SW-1:1]};
         if (bit_cnt_q == PS2_CNT_W'(PS2_FRAME_BITS - 1)) begin
            bit_cnt_d = '0;
            push_d    = frame_ok(frame_c);
            byte_d    = frame_c.data;
         end else begin
            bit_cnt_d = bit_cnt_q + PS2_CNT_W'(1);
         end
      end else if ((IDLE_TIMEOUT != 0) && (bit_cnt_q != '0)) begin
         // A stalled partial frame is dropped so the next start bit realigns.
         if (idle_q == TW'(IDLE_TIMEOUT - 1)) begin
            bit_cnt_d = '0;
         end else begin
            idle_d = idle_q + TW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         clk_sync_q  <= '1;
         data_sync_q <= '1;
         shift_q     <= '0;
         bit_cnt_q   <= '0;
         idle_q      <= '0;
         push_q      <= 1'b0;
         byte_q      <= '0;
      end else begin
         clk_sync_q  <= clk_sync_d;
         data_sync_q <= data_sync_d;
         shift_q     <= shift_d;
         bit_cnt_q   <= bit_cnt_d;
         idle_q      <= idle_d;
         push_q      <= push_d;
         byte_q      <= byte_d;
      end
   end

   ps2_rx_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (clrn),
      .push     (push_q),
      .wdata    (byte_q),
      .pop      (~host.nextdata_n),
      .rdata    (host.data),
      .ready    (host.ready),
      .overflow (host.overflow)
   );

endmodule

// File: tb/tb_ps2_kbd_receiver.sv
// Directed bench for ps2_kbd_receiver: frames driven on the PS/2 pins, bytes popped and checked.
module tb_ps2_kbd_receiver;

   logic clk = 1'b0;
   logic clrn;
   logic ps2_clk;
   logic ps2_data;
   int   checks = 0;
   int   errors = 0;

   ps2_kbd_receiver_if host ();

   ps2_kbd_receiver #(
      .FIFO_DEPTH   (8),
      .SYNC_STAGES  (3),
      .IDLE_TIMEOUT (200)
   ) dut (
      .clk      (clk),
      .clrn     (clrn),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .host     (host)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [10:0] mk(input logic [7:0] b, input logic flip_par, input logic stop);
      return {stop, (~(^b)) ^ flip_par, b, 1'b0};
   endfunction

   task automatic send_bits(input logic [10:0] f, input int n);
      for (int i = 0; i < n; i++) begin
         ps2_data = f[i];
         tick(4);
         ps2_clk = 1'b0;
         tick(8);
         ps2_clk = 1'b1;
         tick(4);
      end
   endtask

   task automatic send(input logic [7:0] b);
      send_bits(mk(b, 1'b0, 1'b1), 11);
      tick(8);
   endtask

   task automatic pop1();
      host.nextdata_n = 1'b0;
      tick(1);
      host.nextdata_n = 1'b1;
      tick(1);
   endtask

   initial begin
      clrn            = 1'b0;
      ps2_clk         = 1'b1;
      ps2_data        = 1'b1;
      host.nextdata_n = 1'b1;
      tick(3);
      check("rst_ready", 32'(host.ready), 32'h0);
      check("rst_overflow", 32'(host.overflow), 32'h0);
      check("rst_data", 32'(host.data), 32'h00);
      clrn = 1'b1;
      tick(3);

      // Single byte then pop
      send(8'h1C);
      check("1c_ready", 32'(host.ready), 32'h1);
      check("1c_data", 32'(host.data), 32'h1C);
      check("1c_overflow", 32'(host.overflow), 32'h0);
      pop1();
      check("1c_popped_ready", 32'(host.ready), 32'h0);

      // Two bytes, ordered pops
      send(8'hF0);
      send(8'h1C);
      check("two_first", 32'(host.data), 32'hF0);
      pop1();
      check("two_second", 32'(host.data), 32'h1C);
      check("two_second_ready", 32'(host.ready), 32'h1);
      pop1();
      check("two_empty", 32'(host.ready), 32'h0);

      // Bad parity and bad stop are dropped
      send_bits(mk(8'h1C, 1'b1, 1'b1), 11);
      tick(8);
      check("badpar_ready", 32'(host.ready), 32'h0);
      send_bits(mk(8'h1C, 1'b0, 1'b0), 11);
      tick(8);
      check("badstop_ready", 32'(host.ready), 32'h0);
      send(8'h2A);
      check("after_bad_data", 32'(host.data), 32'h2A);
      check("after_bad_ready", 32'(host.ready), 32'h1);
      pop1();
      check("after_bad_empty", 32'(host.ready), 32'h0);

      // Held strobe pops one byte per cycle
      send(8'h11);
      send(8'h22);
      send(8'h33);
      host.nextdata_n = 1'b0;
      tick(2);
      host.nextdata_n = 1'b1;
      tick(1);
      check("hold_data", 32'(host.data), 32'h33);
      check("hold_ready", 32'(host.ready), 32'h1);
      pop1();
      check("hold_empty", 32'(host.ready), 32'h0);

      // Nine frames into an eight-deep FIFO
      for (int i = 1; i <= 9; i++) send(8'(i));
      check("ovf_flag", 32'(host.overflow), 32'h1);
      for (int i = 1; i <= 8; i++) begin
         check($sformatf("ovf_pop%0d", i), 32'(host.data), 32'(i));
         pop1();
      end
      check("ovf_drained", 32'(host.ready), 32'h0);
      check("ovf_sticky", 32'(host.overflow), 32'h1);

      // Partial frame abandoned by the idle timeout
      send_bits(mk(8'hFF, 1'b0, 1'b1), 5);
      tick(400);
      check("to_partial_ready", 32'(host.ready), 32'h0);
      send(8'h5A);
      check("to_data", 32'(host.data), 32'h5A);
      check("to_ready", 32'(host.ready), 32'h1);

      // Reset mid-frame with two bytes queued
      send(8'h34);
      send_bits(mk(8'h77, 1'b0, 1'b1), 4);
      clrn = 1'b0;
      #1;
      check("mid_rst_ready", 32'(host.ready), 32'h0);
      check("mid_rst_overflow", 32'(host.overflow), 32'h0);
      check("mid_rst_data", 32'(host.data), 32'h00);
      tick(2);
      clrn = 1'b1;
      tick(2);
      send(8'h12);
      check("post_rst_data", 32'(host.data), 32'h12);
      check("post_rst_ready", 32'(host.ready), 32'h1);
      pop1();
      check("post_rst_empty", 32'(host.ready), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
